// File: rtl/teclado_pkg.sv
// ============================================================================
// teclado_pkg: shared types, keymap and helpers for the 4x4 keypad reader.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package teclado_pkg;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  typedef struct packed {
    logic       valida;
    logic [1:0] idx;
  } fila_t;

  // Indexed [row][col]; '*' encodes as E and '#' as F.
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic fila_t fila_unica(input logic [3:0] filas);
    fila_t res;
    res = '0;
    case (filas)
      4'b1110: begin res.valida = 1'b1; res.idx = 2'd0; end
      4'b1101: begin res.valida = 1'b1; res.idx = 2'd1; end
      4'b1011: begin res.valida = 1'b1; res.idx = 2'd2; end
      4'b0111: begin res.valida = 1'b1; res.idx = 2'd3; end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff: two-flop synchroniser for asynchronous inputs, resets to all-ones.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lector_teclado.sv
// ============================================================================
// lector_teclado: 4x4 keypad scanner with press/release debounce and keymap.
// Optional auto-repeat while held: define TECLADO_REPEAT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lector_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas_n,
  output logic [3:0] columnas_n,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       filas_s;
  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       fila;
  logic [3:0]       patron;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  fila_t            det;

`ifdef TECLADO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  // The pulse is registered, so each trigger fires one cycle before it shows.
  localparam logic [REP_W-1:0] REP_PRIMERO   = REP_W'(REPEAT_DELAY - 2);
  localparam logic [REP_W-1:0] REP_SIGUIENTE = REP_W'(REPEAT_RATE - 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_primero;
`endif

  sync_2ff #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (filas_n),
    .q   (filas_s)
  );

  assign det = fila_unica(filas_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= SCAN;
      col_idx          <= 2'd0;
      columnas_n       <= 4'b1110;
      tecla            <= 4'h0;
      tecla_valida     <= 1'b0;
      tecla_presionada <= 1'b0;
      fila             <= 2'd0;
      patron           <= 4'hF;
      div_cnt          <= '0;
      deb_cnt          <= '0;
`ifdef TECLADO_REPEAT_EN
      rep_cnt          <= '0;
      rep_primero      <= 1'b1;
`endif
    end else begin
      tecla_valida <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (det.valida) begin
              fila    <= det.idx;
              patron  <= filas_s;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx    <= col_idx + 2'd1;
              columnas_n <= col_drive(col_idx + 2'd1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (filas_s != patron) begin
            state      <= SCAN;
            div_cnt    <= '0;
            col_idx    <= col_idx + 2'd1;
            columnas_n <= col_drive(col_idx + 2'd1);
          end else if (deb_cnt == DEB_LAST) begin
            state            <= EMIT;
            tecla            <= KEYMAP[fila][col_idx];
            tecla_valida     <= 1'b1;
            tecla_presionada <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        EMIT: begin
          state <= HOLD;
`ifdef TECLADO_REPEAT_EN
          rep_cnt     <= '0;
          rep_primero <= 1'b1;
`endif
        end
        HOLD: begin
          if (filas_s == 4'hF) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
`ifdef TECLADO_REPEAT_EN
          else if (rep_cnt == (rep_primero ? REP_PRIMERO : REP_SIGUIENTE)) begin
            tecla_valida <= 1'b1;
            rep_cnt      <= '0;
            rep_primero  <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (filas_s != 4'hF) begin
            state <= HOLD;
          end else if (deb_cnt == DEB_LAST) begin
            tecla_presionada <= 1'b0;
            state            <= SCAN;
            div_cnt          <= '0;
            col_idx          <= col_idx + 2'd1;
            columnas_n       <= col_drive(col_idx + 2'd1);
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lector_teclado.sv
// ============================================================================
// tb_lector_teclado: scoreboard bench for lector_teclado with a keypad model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lector_teclado;
  import teclado_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int REPEAT_DELAY    = 40;
  localparam int REPEAT_RATE     = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] filas_n;
  logic [3:0] columnas_n;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_presionada;

  logic [15:0] pulsadas;
  logic [3:0]  esperados [$];
  int          tiempos [$];
  int          checks  = 0;
  int          errores = 0;
  int          ciclo   = 0;
  logic        valida_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  lector_teclado #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .filas_n          (filas_n),
    .columnas_n       (columnas_n),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .tecla_presionada (tecla_presionada)
  );

  // Keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    filas_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pulsadas[r*4+c] && !columnas_n[c]) filas_n[r] = 1'b0;
  end

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errores++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      valida_prev = 1'b0;
    end else begin
      if (tecla_valida) begin
        tiempos.push_back(ciclo);
        chequear("pulso_doble", {31'd0, valida_prev}, 32'd0);
        if (esperados.size() == 0) chequear("pulso_inesperado", {31'd0, tecla_valida}, 32'd0);
        else chequear("tecla", {28'd0, tecla}, {28'd0, esperados.pop_front()});
      end
      valida_prev = tecla_valida;
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses a key held h cycles past its first pulse produces beyond that one.
  function automatic int repeticiones(input int h);
`ifdef TECLADO_REPEAT_EN
    return (h + 2 >= REPEAT_DELAY) ? 1 + (h + 2 - REPEAT_DELAY) / REPEAT_RATE : 0;
`else
    return 0;
`endif
  endfunction

  task automatic pulsar(input int r, input int c, input logic [3:0] codigo,
                        input int h, input bit medir);
    int t;
    for (int i = 0; i < 1 + repeticiones(h); i++) esperados.push_back(codigo);
    pulsadas[r*4+c] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!tecla_valida && t < 200) begin
      @(negedge clk);
      t++;
    end
    chequear("timeout_pulso", {31'd0, tecla_valida}, 32'd1);
    ciclos(h);
    pulsadas[r*4+c] = 1'b0;
    if (medir) begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      chequear("presionada_alta", {31'd0, tecla_presionada}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chequear("presionada_baja", {31'd0, tecla_presionada}, 32'd0);
    end
    t = 0;
    while (tecla_presionada && t < 40) begin
      ciclos(1);
      t++;
    end
    chequear("soltada", {31'd0, tecla_presionada}, 32'd0);
    ciclos(5);
  endtask

  task automatic rotacion();
    logic [3:0] esperado [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [3:0] prev;
    int t = 0;
    while (columnas_n != 4'b1110 && t < 40) begin
      ciclos(1);
      t++;
    end
    chequear("rot_inicio", {28'd0, columnas_n}, 32'hE);
    for (int i = 0; i < 4; i++) begin
      prev = columnas_n;
      t = 0;
      while (columnas_n == prev && t < 10) begin
        ciclos(1);
        t++;
      end
      chequear("rotacion", {28'd0, columnas_n}, {28'd0, esperado[i]});
    end
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    pulsadas = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chequear("rst_columnas", {28'd0, columnas_n}, 32'hE);
    chequear("rst_tecla", {28'd0, tecla}, 32'h0);
    chequear("rst_valida", {31'd0, tecla_valida}, 32'd0);
    chequear("rst_presionada", {31'd0, tecla_presionada}, 32'd0);
    ciclos(2);

    // Long hold of '6', with release timing measured.
    pulsar(1, 2, 4'h6, 75, 1'b1);

    // Bouncing contact on r0/c0 never settles long enough.
    for (int i = 0; i < 20; i++) begin
      pulsadas[0] = ~pulsadas[0];
      ciclos(3);
    end
    pulsadas[0] = 1'b0;
    ciclos(20);
    rotacion();

    pulsar(3, 0, 4'hE, 20, 1'b0);
    pulsar(3, 2, 4'hF, 20, 1'b0);
    pulsar(3, 3, 4'hD, 20, 1'b0);

    // Two rows low on one column is a ghost and must be skipped.
    pulsadas[1] = 1'b1;
    pulsadas[9] = 1'b1;
    rotacion();
    pulsadas = '0;
    ciclos(10);

    // Reset in the middle of a debounce abandons the press.
    pulsadas[5] = 1'b1;
    t = 0;
    while (dut.state != DEBOUNCE && t < 60) begin
      ciclos(1);
      t++;
    end
    chequear("llega_debounce", {31'd0, dut.state == DEBOUNCE}, 32'd1);
    ciclos(4);
    rst      = 1'b1;
    pulsadas = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chequear("rst2_columnas", {28'd0, columnas_n}, 32'hE);
    chequear("rst2_tecla", {28'd0, tecla}, 32'h0);
    chequear("rst2_valida", {31'd0, tecla_valida}, 32'd0);
    chequear("rst2_presionada", {31'd0, tecla_presionada}, 32'd0);
    ciclos(40);

    // Hold 'A' long enough for three auto-repeats when enabled.
    tiempos.delete();
    pulsar(0, 3, 4'hA, 64, 1'b0);
`ifdef TECLADO_REPEAT_EN
    chequear("n_pulsos", tiempos.size(), 32'd4);
    if (tiempos.size() == 4) begin
      chequear("rep_retardo", tiempos[1] - tiempos[0], REPEAT_DELAY);
      chequear("rep_ritmo1", tiempos[2] - tiempos[1], REPEAT_RATE);
      chequear("rep_ritmo2", tiempos[3] - tiempos[2], REPEAT_RATE);
    end
`else
    chequear("n_pulsos", tiempos.size(), 32'd1);
`endif

    ciclos(10);
    chequear("cola_vacia", esperados.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end

endmodule

`default_nettype wire
